mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle variant of the team's MIPS datapath.
- The datapath shares one memory port for instruction and data, and one ALU for PC increment, branch target and execute.
- The FSM issues per-cycle datapath enables and mux selects from the opcode.
- It handles a variable-latency memory handshake with timeout, traps illegal opcodes, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles on mem_ready before trapping (legal range 1..255).

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- opcode  input  6  inst[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemToReg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  write register: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = rs.
- ALUSrcB  output  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- ALUOp  output  2  0 = add, 1 = sub, 2 = funct-decoded.
- PCSource  output  2  0 = ALU result, 1 = ALUOut, 2 = jump address.
- trap  output  1  sticky; the controller is halted in TRAP.
- trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = memory timeout.
- state  output  4  current state encoding, for debug.
- instr_count  output  32  retired-instruction counter.

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, trap=0, trap_cause=0, instr_count=0, wait counter=0.
  - All combinational outputs take their FETCH values immediately.
  - Reset asserted mid-access abandons that access; no write is committed after reset asserts.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=15.
- Every signal not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (precomputes the branch target). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other -> TRAP with cause=1
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Retires; next state FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until mem_ready, then retire to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0. Retires to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Retires to FETCH.
- JUMP: PCWrite=1, PCSource=2. Retires to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Retires to FETCH.
- Cycle counts with mem_ready always 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each wait cycle adds 1.
- Retire: instr_count increments by 1 on the clock edge leaving a retiring state.
  - Wraps from 0xFFFFFFFF to 0 with no flag.
- Wait counter (8-bit):
  - Clears on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - Increments on each cycle in those states with mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with cause=2.
  - A mem_ready arriving on the same cycle as the limit wins: no trap.
- TRAP: all enables 0, MemRead=0, MemWrite=0. State holds until reset. instr_count frozen.
- Outputs must be glitch-free with respect to opcode outside DECODE. Only IRWrite and PCWrite in FETCH depend on an input (mem_ready).

Test Plan:
- Reset, then R-type (opcode 000000) with mem_ready=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7; instr_count=1 after 4 cycles.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> 8 cycles total; MemRead=1 and IorD=1 held throughout MEMRD; MEMWB has RegWrite=1, MemToReg=1.
- Sequence sw, beq, j, addi with mem_ready=1 -> 4+3+3+4 = 14 cycles; instr_count=4; PCWriteCond pulses once in state 8; PCWrite=1 with PCSource=2 in state 9.
- Opcode 111111 in DECODE -> state=15 next cycle, trap=1, trap_cause=1; remains so for 20 further cycles; instr_count unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause=2 after exactly 4 wait cycles; a repeat with mem_ready=1 on the 4th wait cycle -> DECODE, no trap.
- rst pulled low mid-MEMWR for half a cycle -> state=0, instr_count=0, MemWrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Moore control FSM for a multicycle MIPS datapath that uses one
//               shared memory port and one shared ALU. Issues per-state enables
//               and mux selects, waits on a variable-latency memory with a
//               timeout, traps illegal opcodes and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    localparam logic [1:0] c_CAUSE_NONE    = 2'd0;
    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'd2;

    // Compared against the post-increment wait count, so 9 bits avoid overflow.
    localparam logic [8:0] c_TIMEOUT = 9'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [1:0]  r_cause;
    logic [31:0] r_count;

    logic        w_retire;
    logic [1:0]  w_cause;
    logic        w_wait_state;
    logic        w_timeout;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR);
    // This stalled cycle is the one that brings the wait count to the limit.
    assign w_timeout    = !mem_ready && (({1'b0, r_wait} + 9'd1) == c_TIMEOUT);

    // Next-state selection, retire strobe and trap cause for the TRAP entry.
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_cause  = c_CAUSE_NONE;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = c_CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = c_CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: w_next = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = c_CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = c_CAUSE_TIMEOUT;
                end
            end
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // State, wait counter, trap cause and retire counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_cause <= c_CAUSE_NONE;
            r_count <= 32'd0;
        end else begin
            r_state <= w_next;
            // Counts only consecutive stalled cycles within one access; any
            // completion or state change starts the next access from zero.
            if (w_wait_state && !mem_ready && (w_next == r_state)) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_cause <= w_cause;
            end
            if (w_retire) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Moore outputs decoded from the state register; only FETCH looks at mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'd3;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign trap        = (r_state == S_TRAP);
    assign trap_cause  = r_cause;
    assign state       = r_state;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Self-checking bench for mips_multicycle_ctrl. An instruction-
//               level model expands each instruction (plus its memory wait
//               cycles) into the expected state walk; each visited state is
//               checked against the control-word table for that state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 4;

    localparam logic [5:0] c_R    = 6'b000000;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_ADDI = 6'b001000;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;
    int m_count = 0;

    logic [15:0] w_ctrl;
    assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .trap(trap), .trap_cause(trap_cause),
        .state(state), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word expected in a given state, straight from the state table.
    function automatic logic [15:0] exp_ctrl(input int s, input logic rdy);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, op = 0, pcs = 0;
        case (s)
            0:  begin pcw = rdy; irw = rdy; mrd = 1; sb = 2'd1; end
            1:  sb = 2'd3;
            2:  begin sa = 1; sb = 2'd2; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin sa = 1; op = 2'd2; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; op = 2'd1; pcwc = 1; pcs = 2'd1; end
            9:  begin pcw = 1; pcs = 2'd2; end
            10: begin sa = 1; sb = 2'd2; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, op, pcs};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return (op == c_R) || (op == c_LW) || (op == c_SW) ||
               (op == c_BEQ) || (op == c_J) || (op == c_ADDI);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle in an expected state; entered and left at posedge+1.
    task automatic cyc(input int s, input logic rdy, input logic [5:0] op);
        opcode    = op;
        mem_ready = rdy;
        #2;
        chk("state", 32'(state), 32'(s));
        chk("ctrl", 32'(w_ctrl), 32'(exp_ctrl(s, rdy)));
        chk("trap", 32'(trap), 32'd0);
        chk("count_hold", instr_count, 32'(m_count));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(w_ctrl), 32'(exp_ctrl(0, mem_ready)));
        chk("rst_count", instr_count, 32'd0);
        chk("rst_trap", {30'd0, trap_cause} | {31'd0, trap}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_count = 0;
    endtask

    // Fetch through decode, with wf stalled fetch cycles.
    task automatic fetch_decode(input logic [5:0] op, input int wf);
        for (int i = 0; i < wf; i++) cyc(0, 1'b0, 6'($urandom));
        cyc(0, 1'b1, 6'($urandom));
        cyc(1, 1'($urandom), op);
    endtask

    // Full instruction walk; wm is the number of stalled data-memory cycles.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        fetch_decode(op, wf);
        case (op)
            c_R:  begin cyc(6, 1'($urandom), op); cyc(7, 1'($urandom), op); end
            c_LW: begin
                cyc(2, 1'($urandom), op);
                for (int i = 0; i < wm; i++) cyc(3, 1'b0, op);
                cyc(3, 1'b1, op);
                cyc(4, 1'($urandom), op);
            end
            c_SW: begin
                cyc(2, 1'($urandom), op);
                for (int i = 0; i < wm; i++) cyc(5, 1'b0, op);
                cyc(5, 1'b1, op);
            end
            c_BEQ: cyc(8, 1'($urandom), op);
            c_J:   cyc(9, 1'($urandom), op);
            default: begin cyc(10, 1'($urandom), op); cyc(11, 1'($urandom), op); end
        endcase
        m_count++;
        chk("retire_count", instr_count, 32'(m_count));
    endtask

    task automatic trap_hold(input logic [1:0] cause, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            opcode    = 6'($urandom);
            #2;
            chk("trap_state", 32'(state), 32'd15);
            chk("trap_flag", 32'(trap), 32'd1);
            chk("trap_cause", 32'(trap_cause), 32'(cause));
            chk("trap_ctrl", 32'(w_ctrl), 32'd0);
            chk("trap_count", instr_count, 32'(m_count));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] legal [6];
        logic [5:0] op;
        legal = '{c_R, c_LW, c_SW, c_BEQ, c_J, c_ADDI};
        rst = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'd0;
        do_reset();

        // Directed walks: R-type, lw with 3 stalls, then sw/beq/j/addi.
        run_instr(c_R, 0, 0);
        run_instr(c_LW, 0, 3);
        run_instr(c_SW, 0, 0);
        run_instr(c_BEQ, 0, 0);
        run_instr(c_J, 0, 0);
        run_instr(c_ADDI, 0, 0);

        // Random legal instructions with stalls below the timeout.
        for (int n = 0; n < 40; n++) begin
            run_instr(legal[$urandom_range(0, 5)], $urandom_range(0, MEM_TIMEOUT - 1),
                      $urandom_range(0, MEM_TIMEOUT - 1));
        end

        // Illegal opcode traps and holds with the count frozen.
        fetch_decode(6'b111111, 0);
        trap_hold(2'd1, 20);
        for (int n = 0; n < 3; n++) begin
            do_reset();
            run_instr(legal[$urandom_range(0, 5)], 0, 0);
            do op = 6'($urandom); while (is_legal(op));
            fetch_decode(op, $urandom_range(0, MEM_TIMEOUT - 1));
            trap_hold(2'd1, 3);
        end

        // Fetch timeout after exactly MEM_TIMEOUT stalled cycles.
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT; i++) cyc(0, 1'b0, 6'($urandom));
        trap_hold(2'd2, 5);

        // Ready on the last permitted stall cycle wins over the timeout.
        do_reset();
        run_instr(c_ADDI, MEM_TIMEOUT - 1, 0);

        // Load-data timeout.
        fetch_decode(c_LW, 0);
        cyc(2, 1'b0, c_LW);
        for (int i = 0; i < MEM_TIMEOUT; i++) cyc(3, 1'b0, c_LW);
        trap_hold(2'd2, 3);

        // Asynchronous reset in the middle of a stalled store.
        do_reset();
        run_instr(c_BEQ, 0, 0);
        fetch_decode(c_SW, 0);
        cyc(2, 1'b0, c_SW);
        cyc(5, 1'b0, c_SW);
        mem_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_count", instr_count, 32'd0);
        chk("async_memwrite", 32'(MemWrite), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_count = 0;
        run_instr(c_R, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
